// File: rtl/mul_add.sv
// Signed multiply-add (quotient*divisor + remainder) by radix-2 shift-add, one multiplier bit per cycle.
// Latency MULTIPLIER_WIDTH+1 edges from accept to valid_out; requests while busy are dropped, no queuing.
module mul_add #(
  parameter int MULTIPLICAND_WIDTH = 64,
  parameter int MULTIPLIER_WIDTH   = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  input  logic [MULTIPLICAND_WIDTH-1:0] quotient,
  input  logic [MULTIPLIER_WIDTH-1:0]   divisor,
  input  logic [MULTIPLIER_WIDTH-1:0]   remainder,
  output logic [MULTIPLICAND_WIDTH-1:0] result,
  output logic                          valid_out,
  output logic                          overflow,
  output logic                          busy
);

  localparam int QW = MULTIPLICAND_WIDTH;
  localparam int DW = MULTIPLIER_WIDTH;
  localparam int AW = QW + DW;
  localparam int SW = AW + 1;
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, LOOP, EPILOGUE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   mcand_sh;
  logic [DW-1:0]   mplier;
  logic [DW-1:0]   addend;
  logic            prod_neg;
  logic [CW-1:0]   cnt;
  logic [QW-1:0]   q_mag;
  logic [DW-1:0]   d_mag;
  logic [SW-1:0]   prod_s;
  logic [SW-1:0]   sum_s;
  logic            sum_ovf;
  logic            last_bit;

  // Unsigned magnitudes keep the most-negative value exact (e.g. 2^63).
  assign q_mag    = quotient[QW-1] ? (~quotient + QW'(1)) : quotient;
  assign d_mag    = divisor[DW-1]  ? (~divisor + DW'(1))  : divisor;
  assign last_bit = (cnt == CW'(DW-1));

  assign prod_s  = prod_neg ? (~{1'b0, acc} + SW'(1)) : {1'b0, acc};
  assign sum_s   = prod_s + {{(SW-DW){addend[DW-1]}}, addend};
  assign sum_ovf = (sum_s[SW-1:QW-1] != {(SW-QW+1){sum_s[QW-1]}});

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE:     if (valid_in) state_nxt = LOOP;
      LOOP: begin
        busy = 1'b1;
        if (last_bit) state_nxt = EPILOGUE;
      end
      EPILOGUE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      mcand_sh  <= '0;
      mplier    <= '0;
      addend    <= '0;
      prod_neg  <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      overflow  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            mcand_sh <= {{DW{1'b0}}, q_mag};
            mplier   <= d_mag;
            prod_neg <= quotient[QW-1] ^ divisor[DW-1];
            addend   <= remainder;
            acc      <= '0;
            cnt      <= '0;
          end
        end
        LOOP: begin
          if (mplier[0]) acc <= acc + mcand_sh;
          mcand_sh <= mcand_sh << 1;
          mplier   <= mplier >> 1;
          cnt      <= cnt + CW'(1);
        end
        EPILOGUE: begin
          result    <= sum_s[QW-1:0];
          overflow  <= sum_ovf;
          valid_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_add.sv
// Randomized and directed checks of mul_add against a wide-integer reference model.
module tb_mul_add;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [63:0] quotient = '0;
  logic [31:0] divisor = '0;
  logic [31:0] remainder = '0;
  logic [63:0] result;
  logic        valid_out;
  logic        overflow;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  mul_add #(.MULTIPLICAND_WIDTH(64), .MULTIPLIER_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .quotient(quotient), .divisor(divisor), .remainder(remainder),
    .result(result), .valid_out(valid_out), .overflow(overflow), .busy(busy)
  );

  // Exact signed arithmetic at 128 bits: {overflow, low 64 bits}.
  function automatic logic [64:0] calc(input logic [63:0] q, input logic [31:0] d, input logic [31:0] r);
    logic signed [127:0] a, b, c, full, hi, lo;
    a    = $signed(q);
    b    = $signed(d);
    c    = $signed(r);
    full = a * b + c;
    hi   = (128'sd1 <<< 63) - 128'sd1;
    lo   = -(128'sd1 <<< 63);
    return {(full > hi) || (full < lo), full[63:0]};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: a request taken while idle completes 33 edges later; nothing else is accepted meanwhile.
  int          remain = 0;
  logic        m_vld = 1'b0;
  logic        m_ovf = 1'b0;
  logic [63:0] m_res = '0;
  logic [64:0] pend = '0;

  always @(posedge clk) begin
    if (reset) begin
      remain <= 0;
      m_vld  <= 1'b0;
      m_res  <= '0;
      m_ovf  <= 1'b0;
    end else if (remain != 0) begin
      remain <= remain - 1;
      m_vld  <= (remain == 1);
      if (remain == 1) {m_ovf, m_res} <= pend;
    end else begin
      m_vld <= 1'b0;
      if (valid_in) begin
        remain <= 33;
        pend   <= calc(quotient, divisor, remainder);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid_out", {63'b0, valid_out}, {63'b0, m_vld});
      check("busy", {63'b0, busy}, {63'b0, remain != 0});
      check("result", result, m_res);
      check("overflow", {63'b0, overflow}, {63'b0, m_ovf});
    end
  end

  function automatic logic [63:0] pick64();
    case ($urandom_range(0, 5))
      0:       return 64'h0;
      1:       return 64'h8000_0000_0000_0000;
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return 64'(signed'($urandom_range(0, 200)) - 100);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'(signed'($urandom_range(0, 200)) - 100);
      default: return $urandom;
    endcase
  endfunction

  task automatic op(input string nm, input logic [63:0] q, input logic [31:0] d, input logic [31:0] r,
                    input logic [63:0] er, input logic eo);
    int lat;
    @(posedge clk); #1;
    valid_in = 1'b1; quotient = q; divisor = d; remainder = r;
    @(posedge clk); #1;
    valid_in = 1'b0; quotient = {$urandom, $urandom}; divisor = $urandom; remainder = $urandom;
    lat = 0;
    while (!valid_out && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, " latency"}, 64'(lat), 64'd33);
    check({nm, " result"}, result, er);
    check({nm, " overflow"}, {63'b0, overflow}, {63'b0, eo});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    reset = 1'b1;
    valid_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset result", result, 64'h0);
    check("reset overflow", {63'b0, overflow}, 64'h0);
    check("reset valid_out", {63'b0, valid_out}, 64'h0);
    check("reset busy", {63'b0, busy}, 64'h0);
    chk_en = 1'b1;
    reset = 1'b0;
    valid_in = 1'b0;

    op("mac_pos", 64'd5, 32'd7, 32'd3, 64'd38, 1'b0);
    op("mac_neg", 64'hFFFF_FFFF_FFFF_FFFB, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFDA, 1'b0);
    op("mac_negneg", 64'hFFFF_FFFF_FFFF_FFFB, 32'hFFFF_FFF9, 32'd3, 64'd38, 1'b0);
    op("ovf_pos", 64'h4000_0000_0000_0000, 32'd2, 32'd0, 64'h8000_0000_0000_0000, 1'b1);
    op("ovf_min", 64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 32'd0, 64'h8000_0000_0000_0000, 1'b1);
    op("min_fit", 64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    op("div_zero", 64'h1234, 32'd0, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    op("q_zero", 64'd0, 32'h8000_0000, 32'h7FFF_FFFF, 64'h0000_0000_7FFF_FFFF, 1'b0);
    op("d_min", 64'd3, 32'h8000_0000, 32'd0, 64'hFFFF_FFFE_8000_0000, 1'b0);

    // Requests during LOOP cycles 3 and 20 must be dropped.
    @(posedge clk); #1;
    valid_in = 1'b1; quotient = 64'd100; divisor = 32'd3; remainder = 32'd1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    valid_in = 1'b1; quotient = 64'd9; divisor = 32'd9; remainder = 32'd9;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    valid_in = 1'b1; quotient = 64'd77; divisor = 32'd2; remainder = 32'd0;
    @(posedge clk); #1;
    valid_in = 1'b0;
    nv = 0;
    repeat (60) begin
      if (valid_out) begin
        nv++;
        check("ignore result", result, 64'd301);
      end
      @(posedge clk); #1;
    end
    check("ignore count", 64'(nv), 64'd1);

    // Continuous requests with operands changing every cycle.
    nv = 0;
    valid_in = 1'b1;
    repeat (150) begin
      quotient = pick64(); divisor = pick32(); remainder = pick32();
      @(posedge clk); #1;
      if (valid_out) nv++;
    end
    valid_in = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("stream count", 64'(nv >= 4), 64'd1);

    // Reset in the middle of LOOP aborts the operation.
    @(posedge clk); #1;
    valid_in = 1'b1; quotient = 64'd11; divisor = 32'd11; remainder = 32'd11;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1; valid_in = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; valid_in = 1'b0;
    check("abort busy", {63'b0, busy}, 64'h0);
    check("abort result", result, 64'h0);
    check("abort valid_out", {63'b0, valid_out}, 64'h0);
    nv = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_out) nv++;
    end
    check("abort no valid_out", 64'(nv), 64'd0);
    op("after_reset", 64'd1000, 32'hFFFF_FFFE, 32'd5, 64'hFFFF_FFFF_FFFF_F835, 1'b0);

    // Random traffic with occasional resets.
    repeat (600) begin
      @(posedge clk); #1;
      valid_in  = ($urandom_range(0, 3) == 0);
      reset     = ($urandom_range(0, 199) == 0);
      quotient  = pick64();
      divisor   = pick32();
      remainder = pick32();
    end
    @(posedge clk); #1;
    reset = 1'b0; valid_in = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
